// File: rtl/mult_seq.sv
// Multi-cycle shift-add multiplier (MUL/MULH/MULHU/MULHSU), K multiplier bits per cycle.
// Optional MULT_SEQ_ZERO_SKIP_EN: a zero operand bypasses the iterations.
module mult_seq #(
  parameter int DATA_ALU = 32,
  parameter int K        = 1
) (
  input  logic                I_CLK,
  input  logic                I_RST,
  input  logic                I_VLD,
  output logic                O_RDY,
  input  logic [DATA_ALU-1:0] I_A,
  input  logic [DATA_ALU-1:0] I_B,
  input  logic [1:0]          I_MODE,
  output logic                O_VLD,
  input  logic                I_RDY,
  output logic [DATA_ALU-1:0] O_RSL
);

  localparam int N  = DATA_ALU / K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * DATA_ALU;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         acc;
  logic [DATA_ALU-1:0]   mcand, mplier;
  logic                  neg, hi, fix_out;
  logic [CW-1:0]         cnt;
  logic                  neg_a, neg_b;
  logic [DATA_ALU-1:0]   mag_a, mag_b;
  logic [PW-1:0]         pp;
  logic [31:0]           shamt;
  logic                  zero_op;

  // Only MULH treats B as signed; MULH and MULHSU treat A as signed.
  assign neg_a = (I_MODE == 2'b01 || I_MODE == 2'b11) && I_A[DATA_ALU-1];
  assign neg_b = (I_MODE == 2'b01) && I_B[DATA_ALU-1];
  assign mag_a = neg_a ? (~I_A + 1'b1) : I_A;
  assign mag_b = neg_b ? (~I_B + 1'b1) : I_B;

`ifdef MULT_SEQ_ZERO_SKIP_EN
  assign zero_op = (I_A == '0) || (I_B == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign shamt = 32'(cnt) * 32'(K);
  assign pp    = ({{DATA_ALU{1'b0}}, mcand} * {{(PW-K){1'b0}}, mplier[K-1:0]}) << shamt;
  assign O_RDY = (state == IDLE);

  always_ff @(posedge I_CLK) begin
    if (I_RST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (I_VLD) state_nxt = zero_op ? FIX : CALC;
      CALC: if (cnt == CW'(N - 1)) state_nxt = FIX;
      FIX:  if (fix_out) state_nxt = DONE;
      DONE: if (I_RDY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIX spans two edges: sign correction of acc, then the registered result load.
  // A zero-skip request enters FIX already in the load phase with acc cleared.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      hi      <= 1'b0;
      fix_out <= 1'b0;
      cnt     <= '0;
      O_VLD   <= 1'b0;
      O_RSL   <= '0;
    end else begin
      case (state)
        IDLE: if (I_VLD) begin
          mcand   <= mag_a;
          mplier  <= mag_b;
          neg     <= neg_a ^ neg_b;
          hi      <= (I_MODE != 2'b00);
          acc     <= '0;
          cnt     <= '0;
          fix_out <= zero_op;
        end
        CALC: begin
          acc    <= acc + pp;
          mplier <= mplier >> K;
          cnt    <= (cnt == CW'(N - 1)) ? '0 : cnt + 1'b1;
        end
        FIX: begin
          if (!fix_out) begin
            acc     <= neg ? (~acc + 1'b1) : acc;
            fix_out <= 1'b1;
          end else begin
            O_RSL <= hi ? acc[PW-1:DATA_ALU] : acc[DATA_ALU-1:0];
            O_VLD <= 1'b1;
          end
        end
        DONE: if (I_RDY) O_VLD <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
